fetch_queue: RTL
================

# fetch_queue

Decoupling buffer between the fetch stage and decode. Captures each fetched (pc, instr) pair into a small circular queue and presents the oldest entry to decode with a valid/ready handshake, so decode stalls no longer freeze fetch immediately. A flush input discards all buffered instructions when the PC is redirected (PCSrc taken).

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- XLEN, 32, width of pc and instr fields
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (branch/jump redirect)
- in_valid  in  1  fetch presents a pair this cycle
- in_pc  in  XLEN  word address of instruction
- in_instr  in  XLEN  instruction word
- in_ready  out  1  queue accepts a pair this cycle
- out_valid  out  1  head entry valid for decode
- out_pc  out  XLEN  head pc
- out_instr  out  XLEN  head instruction
- out_ready  in  1  decode consumes head this cycle
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: DEPTH-entry array of {pc, instr}; wr_ptr, rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH naturally; count tracked separately (0..DEPTH).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & !flush; does not depend on out_ready (no push into a full queue even if popping).
- out_valid = (count != 0); out_pc/out_instr = array[rd_ptr] when valid, else 0 / NOP (32'h00000013).
- push only: write at wr_ptr, wr_ptr+1, count+1. pop only: rd_ptr+1, count−1. Both: both pointers advance, count unchanged.
- flush (priority over push/pop): next cycle count=0, rd_ptr=wr_ptr=0; same-cycle input dropped, same-cycle pop not counted as consumed by queue (decode must ignore head on flush cycle).
- rst has priority over flush; same effect as flush, plus array contents don't care.
- Reset values: count=0, out_valid=0, out_pc=0, out_instr=NOP, in_ready=1 (after rst deasserts).

## Timing
- Push-to-visible latency: 1 cycle (entry written at edge N, out_valid at N+1).
- Pop takes effect at edge; next head visible the following cycle.
- Full: count==DEPTH → in_ready=0; fetch must hold pc.
- Empty with out_ready=1: out_valid=0, no pop, count stays 0.
- Sustained throughput: 1 pair/cycle when neither full nor stalled.
- Reset mid-operation: all entries lost in one cycle; no partial state.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count==0 and in_valid & !flush, in_pc/in_instr drive outputs combinationally with out_valid=1; if out_ready same cycle, pair is consumed and not written (0-cycle latency); otherwise written normally.
- Undefined: no bypass; strict 1-cycle latency, outputs purely registered-array reads.

## Structure
- Shared cpu package: XLEN, NOP encoding constant (INSTR_NOP = 32'h00000013), default FETCH_QUEUE_DEPTH.
- One sub-module natural: fetch_queue_mem (DEPTH×2·XLEN register array, one write port, one async read port); control/pointers stay in fetch_queue.

## Test plan
- Reset: assert rst with 2 entries loaded → next cycle count=0, out_valid=0, out_instr=32'h00000013, in_ready=1.
- Fill: push pc 0..3 (instr 0xA0..0xA3), out_ready=0 → count=4, in_ready=0, out_pc=0; pop four times → out_pc 0,1,2,3 in order, then out_valid=0.
- Simultaneous: count=2, push pc=10 and pop same cycle → count stays 2, head advances, pc=10 later emerges after older entry.
- Wrap: 10 push/pop cycles at DEPTH=4 → pointers wrap, output order matches input order exactly, count never exceeds 4.
- Flush: count=3, flush with in_valid=1 pc=20 → next cycle count=0, pc=20 never appears at out.
- Bypass (FETCH_QUEUE_BYPASS_EN): empty, in_valid pc=5, out_ready=1 → out_valid=1, out_pc=5 same cycle, count stays 0; without macro out_valid=0 that cycle, 1 next.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared cpu constants for the fetch/decode queue
package fetch_queue_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] INSTR_NOP = 32'h00000013;
    localparam int FETCH_QUEUE_DEPTH = 4;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH-entry register array, one write port, one async read port
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int W = 64,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    // store the incoming pair; contents need no reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular fetch-to-decode buffer with flush; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
module fetch_queue #(
    parameter int DEPTH = fetch_queue_pkg::FETCH_QUEUE_DEPTH,
    parameter int XLEN = fetch_queue_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);
    import fetch_queue_pkg::*;
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [2*XLEN-1:0] rdata;
    logic empty, bypass, push, pop, wr, deq;
    fetch_queue_mem #(.DEPTH(DEPTH), .W(2*XLEN), .AW(AW)) u_mem (
        .clk(clk),
        .we(wr),
        .waddr(wr_ptr),
        .wdata({in_pc, in_instr}),
        .raddr(rd_ptr),
        .rdata(rdata)
    );
    // handshake and head presentation; a bypassed pair consumed on arrival is never stored
    always_comb begin
        empty = count == '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = empty & in_valid & !flush;
`else
        bypass = 1'b0;
`endif
        in_ready = (count != (AW+1)'(DEPTH)) & !flush;
        out_valid = !empty | bypass;
        out_pc = bypass ? in_pc : !empty ? rdata[2*XLEN-1:XLEN] : '0;
        out_instr = bypass ? in_instr : !empty ? rdata[XLEN-1:0] : XLEN'(INSTR_NOP);
        push = in_valid & in_ready;
        pop = out_valid & out_ready;
        wr = push & !(bypass & out_ready);
        deq = pop & !empty;
    end
    // pointers and occupancy; reset and flush both empty the queue in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(deq);
        end
    end
endmodule
